// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings and owner ids for the memory port arbiter
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;
   typedef logic owner_t;
   localparam owner_t OWNER_IF = 1'b0;
   localparam owner_t OWNER_DM = 1'b1;
   function automatic owner_t owner_of(arb_state_t s);
      return (s == ARB_BUSY_D) ? OWNER_DM : OWNER_IF;
   endfunction
endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: counts data grants made while fetch waits and flags when the limit is reached
module arb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!reset || clr) cnt <= '0;
      else if (inc && cnt != LIM) cnt <= cnt + 1'b1;
   end
   assign at_limit = cnt == LIM;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding arbiter sharing the memory port between fetch and data.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_in,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_wstrb,
   output logic                dm_gnt,
   output logic                dm_rvalid,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);
   arb_state_t state;
   owner_t owner;
   logic discard, force_if, pick_d, pick_i, done, resp_if, resp_dm;
   assign busy    = state != ARB_IDLE;
   assign owner   = owner_of(state);
   assign done    = busy && mem_ack;
   assign resp_if = done && owner == OWNER_IF && !discard && !flush_in;
   assign resp_dm = done && owner == OWNER_DM;
   assign pick_d  = state == ARB_IDLE && dm_req && !force_if;
   assign pick_i  = state == ARB_IDLE && if_req && !flush_in && (!dm_req || force_if);
`ifdef ARB_STARVE_GUARD_EN
   logic at_limit;
   arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk(clk),
      .reset(reset),
      .inc(pick_d && if_req),
      .clr(pick_i || !if_req),
      .at_limit(at_limit)
   );
   assign force_if = at_limit && if_req && !flush_in;
`else
   logic [31:0] unused_limit;
   assign unused_limit = STARVE_LIMIT;
   assign force_if = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ARB_IDLE;
         discard   <= 1'b0;
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         if_gnt    <= pick_i;
         dm_gnt    <= pick_d;
         if_rvalid <= resp_if;
         dm_rvalid <= resp_dm;
         if_rdata  <= resp_if ? mem_rdata : '0;
         dm_rdata  <= (resp_dm && !mem_we) ? mem_rdata : '0;
         discard   <= done ? 1'b0 : (discard || (state == ARB_BUSY_I && flush_in));
         if (pick_d || pick_i) begin
            state     <= pick_d ? ARB_BUSY_D : ARB_BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= pick_d && dm_we;
            mem_addr  <= pick_d ? dm_addr : if_addr;
            mem_wdata <= pick_d ? dm_wdata : '0;
            mem_wstrb <= pick_d ? dm_wstrb : '0;
         end else if (done) begin
            state   <= ARB_IDLE;
            mem_req <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a wait-state memory model driving mem_ack.
module tb_mem_port_arbiter;
   logic        clk = 1'b0, reset = 1'b0, flush_in = 1'b0;
   logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
   logic [3:0]  dm_wstrb = '0;
   logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, busy;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   typedef struct packed {logic owner; logic [31:0] data;} exp_t;
   exp_t sb[$];
   exp_t got_e;
   int checks = 0, failures = 0;
   int mem_wait = 0, wait_cnt = 0;
   bit auto_ack = 1'b1;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (
      .clk(clk), .reset(reset), .flush_in(flush_in),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fn(logic [31:0] a);
      return 32'hDEADBEEF + (a - 32'h100);
   endfunction

   // memory model: ack after mem_wait idle cycles of an active request
   always @(negedge clk) begin
      if (auto_ack) begin
         if (!mem_req) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
         end else if (wait_cnt == mem_wait) begin
            mem_ack = 1'b1;
            mem_rdata = fn(mem_addr);
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (if_rvalid || dm_rvalid) begin
         checks++;
         if (if_rvalid && dm_rvalid) begin
            failures++;
            $display("FAIL sb_both_rvalid got=11 exp=one");
         end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got if=%0b dm=%0b exp=none", if_rvalid, dm_rvalid);
         end else begin
            got_e = sb.pop_front();
            if ({dm_rvalid, dm_rvalid ? dm_rdata : if_rdata} !== got_e) begin
               failures++;
               $display("FAIL sb_resp got owner=%0b data=%h exp owner=%0b data=%h",
                        dm_rvalid, dm_rvalid ? dm_rdata : if_rdata, got_e.owner, got_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (busy || sb.size() != 0) begin
         failures++;
         $display("FAIL drain got busy=%0b pending=%0d exp busy=0 pending=0", busy, sb.size());
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy});
      end
      checks++;
      if ({if_rdata, dm_rdata, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {if_rdata, dm_rdata, mem_addr, mem_wdata, mem_wstrb});
      end
      reset = 1'b1;
   endtask

   task automatic test_fetch();
      mem_wait = 2;
      if_req = 1'b1;
      if_addr = 32'h100;
      sb.push_back({1'b0, fn(32'h100)});
      tick();
      checks++;
      if ({if_gnt, dm_gnt, mem_req, mem_we, busy} !== 5'b10101 || mem_addr !== 32'h100) begin
         failures++;
         $display("FAIL fetch_c1 got=%b addr=%h exp=10101 addr=100", {if_gnt, dm_gnt, mem_req, mem_we, busy}, mem_addr);
      end
      if_req = 1'b0;
      tick();
      checks++;
      if ({if_gnt, mem_req, busy, if_rvalid} !== 4'b0110 || mem_addr !== 32'h100) begin
         failures++;
         $display("FAIL fetch_c2 got=%b addr=%h exp=0110 addr=100", {if_gnt, mem_req, busy, if_rvalid}, mem_addr);
      end
      tick();
      checks++;
      if ({mem_req, busy, if_rvalid} !== 3'b110) begin
         failures++;
         $display("FAIL fetch_c3 got=%b exp=110", {mem_req, busy, if_rvalid});
      end
      tick();
      checks++;
      if ({if_rvalid, mem_req, busy} !== 3'b100 || if_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL fetch_c4 got=%b data=%h exp=100 data=deadbeef", {if_rvalid, mem_req, busy}, if_rdata);
      end
      drain();
   endtask

   task automatic test_simultaneous();
      mem_wait = 1;
      if_req = 1'b1;
      if_addr = 32'h100;
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_addr = 32'h200;
      dm_wdata = 32'h55;
      dm_wstrb = 4'hF;
      sb.push_back({1'b1, 32'h0});
      sb.push_back({1'b0, fn(32'h100)});
      tick();
      checks++;
      if ({dm_gnt, if_gnt, mem_req, mem_we} !== 4'b1011 || mem_addr !== 32'h200 || mem_wdata !== 32'h55 || mem_wstrb !== 4'hF) begin
         failures++;
         $display("FAIL simul_store got=%b addr=%h wdata=%h wstrb=%h exp=1011 200 55 f",
                  {dm_gnt, if_gnt, mem_req, mem_we}, mem_addr, mem_wdata, mem_wstrb);
      end
      dm_req = 1'b0;
      dm_we = 1'b0;
      tick();
      checks++;
      if ({mem_req, if_gnt} !== 2'b10) begin
         failures++;
         $display("FAIL simul_hold got=%b exp=10", {mem_req, if_gnt});
      end
      tick();
      checks++;
      if ({dm_rvalid, if_rvalid, mem_req, if_gnt} !== 4'b1000 || dm_rdata !== 32'h0) begin
         failures++;
         $display("FAIL simul_done got=%b rdata=%h exp=1000 rdata=0", {dm_rvalid, if_rvalid, mem_req, if_gnt}, dm_rdata);
      end
      tick();
      checks++;
      if ({if_gnt, mem_req, mem_we} !== 3'b110 || mem_addr !== 32'h100) begin
         failures++;
         $display("FAIL simul_fetch got=%b addr=%h exp=110 addr=100", {if_gnt, mem_req, mem_we}, mem_addr);
      end
      if_req = 1'b0;
      drain();
   endtask

   task automatic test_zero_wait();
      mem_wait = 0;
      if_req = 1'b1;
      if_addr = 32'h300;
      sb.push_back({1'b0, fn(32'h300)});
      sb.push_back({1'b0, fn(32'h300)});
      tick();
      checks++;
      if ({if_gnt, mem_req, if_rvalid} !== 3'b110) begin
         failures++;
         $display("FAIL zw_c1 got=%b exp=110", {if_gnt, mem_req, if_rvalid});
      end
      tick();
      checks++;
      if ({if_gnt, mem_req, if_rvalid, busy} !== 4'b0010) begin
         failures++;
         $display("FAIL zw_c2 got=%b exp=0010", {if_gnt, mem_req, if_rvalid, busy});
      end
      tick();
      checks++;
      if ({if_gnt, mem_req} !== 2'b11) begin
         failures++;
         $display("FAIL zw_c3 got=%b exp=11", {if_gnt, mem_req});
      end
      if_req = 1'b0;
      drain();
   endtask

   task automatic test_flush();
      mem_wait = 2;
      if_req = 1'b1;
      if_addr = 32'h400;
      tick();
      checks++;
      if (if_gnt !== 1'b1) begin
         failures++;
         $display("FAIL flush_gnt got=%b exp=1", if_gnt);
      end
      if_req = 1'b0;
      tick();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      tick();
      checks++;
      if ({if_rvalid, busy, mem_req} !== 3'b000) begin
         failures++;
         $display("FAIL flush_drop got=%b exp=000", {if_rvalid, busy, mem_req});
      end
      mem_wait = 0;
      if_req = 1'b1;
      if_addr = 32'h404;
      tick();
      if_req = 1'b0;
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      checks++;
      if ({if_rvalid, busy, mem_req} !== 3'b000) begin
         failures++;
         $display("FAIL flush_ack_same got=%b exp=000", {if_rvalid, busy, mem_req});
      end
      flush_in = 1'b1;
      if_req = 1'b1;
      if_addr = 32'h408;
      tick();
      checks++;
      if ({if_gnt, busy} !== 2'b00) begin
         failures++;
         $display("FAIL flush_block got=%b exp=00", {if_gnt, busy});
      end
      flush_in = 1'b0;
      sb.push_back({1'b0, fn(32'h408)});
      tick();
      checks++;
      if (if_gnt !== 1'b1 || mem_addr !== 32'h408) begin
         failures++;
         $display("FAIL flush_refetch got=%b addr=%h exp=1 addr=408", if_gnt, mem_addr);
      end
      if_req = 1'b0;
      drain();
      flush_in = 1'b1;
      dm_req = 1'b1;
      dm_addr = 32'h40C;
      sb.push_back({1'b1, fn(32'h40C)});
      tick();
      dm_req = 1'b0;
      tick();
      checks++;
      if (dm_rvalid !== 1'b1 || dm_rdata !== fn(32'h40C)) begin
         failures++;
         $display("FAIL flush_data got=%b data=%h exp=1 data=%h", dm_rvalid, dm_rdata, fn(32'h40C));
      end
      flush_in = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      auto_ack = 1'b0;
      mem_ack = 1'b0;
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_addr = 32'h500;
      tick();
      checks++;
      if ({dm_gnt, mem_req, busy} !== 3'b111) begin
         failures++;
         $display("FAIL rmid_gnt got=%b exp=111", {dm_gnt, mem_req, busy});
      end
      dm_req = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, busy} !== 6'b0 || {if_rdata, dm_rdata} !== 64'h0) begin
         failures++;
         $display("FAIL rmid_reset got=%b rdata=%h exp=0", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, busy}, {if_rdata, dm_rdata});
      end
      reset = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'h12345678;
      tick();
      checks++;
      if ({dm_rvalid, busy, mem_req} !== 3'b000) begin
         failures++;
         $display("FAIL rmid_late_ack got=%b exp=000", {dm_rvalid, busy, mem_req});
      end
      mem_ack = 1'b0;
      auto_ack = 1'b1;
      drain();
   endtask

   task automatic test_starve();
      logic [5:0] exp_order, got_order;
      int n = 0;
`ifdef ARB_STARVE_GUARD_EN
      exp_order = 6'b011011;
`else
      exp_order = 6'b111111;
`endif
      got_order = '0;
      mem_wait = 0;
      for (int i = 0; i < 6; i++) sb.push_back({exp_order[i], exp_order[i] ? fn(32'h600) : fn(32'h700)});
      dm_req = 1'b1;
      dm_we = 1'b0;
      dm_addr = 32'h600;
      if_req = 1'b1;
      if_addr = 32'h700;
      for (int c = 0; c < 60 && n < 6; c++) begin
         tick();
         if (if_gnt || dm_gnt) begin
            got_order[n] = dm_gnt;
            n++;
         end
         if (n == 6) begin
            dm_req = 1'b0;
            if_req = 1'b0;
         end
      end
      dm_req = 1'b0;
      if_req = 1'b0;
      checks++;
      if (n != 6) begin
         failures++;
         $display("FAIL starve_grants got=%0d exp=6", n);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got_order[i] !== exp_order[i]) begin
            failures++;
            $display("FAIL starve_order[%0d] got dm=%b exp dm=%b", i, got_order[i], exp_order[i]);
         end
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fetch();
      test_simultaneous();
      test_zero_wait();
      test_flush();
      test_reset_mid();
      test_starve();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between instruction fetch and the memory stage (load/store issued after execute). It is a non-pipelined, one-outstanding-transaction arbiter: it accepts a request, drives the memory bus until acknowledged, and returns the response to the owner. Fetch responses are discarded when the pipeline is flushed by a taken branch or jump.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive data grants while fetch waits (used only with ARB_STARVE_GUARD_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flush_in  in  1  pipeline flush; kills the in-flight fetch response
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle grant pulse
if_rvalid  out  1  one-cycle fetch response pulse
if_rdata  out  DATA_W  fetch data, valid with if_rvalid
dm_req  in  1  data request; held with payload until dm_gnt
dm_we  in  1  1 = store
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wstrb  in  DATA_W/8  byte strobes
dm_gnt  out  1  one-cycle grant pulse
dm_rvalid  out  1  one-cycle completion pulse (load data or store done)
dm_rdata  out  DATA_W  load data
mem_req  out  1  bus request; held until mem_ack
mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered bus payload
mem_ack  in  1  one-cycle transfer complete
mem_rdata  in  DATA_W  read data, valid with mem_ack
busy  out  1  state != IDLE

Behaviour:
- Reset: when reset==0 at a clk edge, state goes to IDLE. All outputs go to 0, plus discard flag 0 and starve counter 0. Reset takes priority over flush and over any in-flight transaction; mem_req drops the next cycle.
- FSM: IDLE, BUSY_I, BUSY_D.
- IDLE at cycle t, choice made on the edge ending t:
  - dm_req=1: state goes to BUSY_D. Data has priority.
  - else if_req=1 and flush_in=0: state goes to BUSY_I.
  - The payload is registered onto mem_*. At t+1, the matching gnt pulses for exactly one cycle and mem_req=1.
  - A fetch request in the same cycle as flush_in is not granted.
- BUSY_x: mem_req and payload stay stable until mem_ack. Requests are ignored, and no gnt is issued. mem_ack is legal in the first mem_req cycle (zero wait).
- On mem_ack:
  - mem_req goes to 0 next cycle and state returns to IDLE.
  - The owner's rvalid pulses next cycle, with rdata = registered mem_rdata.
  - Minimum request-to-rvalid latency is 2 cycles.
  - IDLE arbitrates again in the same cycle rvalid is high.
- Stores also produce dm_rvalid; dm_rdata is then don't-care but driven 0.
- Flush: flush_in=1 in BUSY_I, or in the cycle that grants fetch, sets the discard flag.
  - The bus transaction still completes.
  - if_rvalid is suppressed for that transaction.
  - The flag clears when the transaction completes.
  - flush_in has no effect on data transactions.
- flush_in with mem_ack in the same cycle in BUSY_I: the response is discarded.
- Outputs are registered except busy (decoded from state).

Optional Feature:
ARB_STARVE_GUARD_EN:
- Defined: a counter increments on each data grant made while if_req=1.
  - It resets on a fetch grant or when if_req=0.
  - When the count equals STARVE_LIMIT, the next IDLE arbitration grants fetch even if dm_req=1, unless flush_in is high.
- Undefined: strict data priority, no counter logic. Fetch can starve while dm_req is held.

Decomposition:
- Shared params file: ARB_IDLE/ARB_BUSY_I/ARB_BUSY_D state encodings (2 bits) and OWNER_IF/OWNER_DM IDs.
- Sub-module arb_starve_ctr (counter + limit compare) is instantiated only under ARB_STARVE_GUARD_EN.
- Everything else is one module.

Test Plan:
1. Fetch only, 2 wait states:
   - Stimulus: if_req=1, if_addr=0x100 at cycle 0; mem_ack=1, mem_rdata=0xDEADBEEF at cycle 3.
   - Response: if_gnt at 1; mem_req 1..3 with we=0, addr=0x100; if_rvalid at 4 with if_rdata=0xDEADBEEF; busy 1..3.
2. Simultaneous requests:
   - Stimulus at cycle 0: if_req with addr 0x100; dm_req with store addr=0x200, wdata=0x55, wstrb=0xF.
   - Response: dm_gnt at 1, store on bus first, dm_rvalid after ack; then if_gnt, fetch on bus.
3. Zero-wait: mem_ack=1 whenever mem_req=1 -> req at 0, gnt at 1, rvalid at 2, next grant at 3.
4. Flush:
   - Stimulus: fetch granted at 1; flush_in pulse at 2; mem_ack at 3.
   - Response: no if_rvalid; busy drops; a subsequent if_req is serviced normally.
5. Reset mid-operation: reset=0 during BUSY_D before ack -> next cycle mem_req=0, all gnt/rvalid/rdata=0, busy=0; a late mem_ack is ignored.
6. Starvation, dm_req and if_req held high continuously:
   - With ARB_STARVE_GUARD_EN and STARVE_LIMIT=2: grant order D,D,I,D,D,I.
   - Without the macro: only data grants.
